// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM state type,
// datapath widths and the active-low segment encoding table.
// SSD_HEX_EN: when defined, nibbles A..F get their letter glyphs;
// otherwise they render blank (they never occur in decimal mode).
package ssd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int SSD_W      = 13;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
`ifdef SSD_HEX_EN
        return SEG_TABLE[nib];
`else
        return (nib > 4'd9) ? SEG_BLANK : SEG_TABLE[nib];
`endif
    endfunction

endpackage

// File: rtl/ssd_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter. A start pulse in IDLE
// captures bin_in; thirteen add-3/shift cycles later done pulses for one
// cycle with the finished BCD word on bcd_out.
// SSD_HEX_EN: when defined, start completes immediately (done in the same
// cycle, bcd_out = zero-extended bin_in) and the engine never goes busy.
module ssd_bcd_conv
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SSD_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int            ITER_W    = $clog2(SSD_W + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(SSD_W - 1);

    state_t              state_reg, state_next;
    logic [SSD_W-1:0]    bin_reg,   bin_next;
    logic [BCD_W-1:0]    bcd_reg,   bcd_next;
    logic [ITER_W-1:0]   iter_reg,  iter_next;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic [SSD_W-1:0]    bin_shift;

    // Per-nibble add-3 correction applied before each shift.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? bcd_reg[gi*4 +: 4] + 4'd3
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // {bcd,bin} shifted left by one, binary MSB moving into the BCD LSB.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[SSD_W-1]};
    assign bin_shift = {bin_reg[SSD_W-2:0], 1'b0};

    assign busy = (state_reg == CONV);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            bcd_reg   <= bcd_next;
            iter_reg  <= iter_next;
        end
    end

    // Next-state, datapath updates and completion strobe.
    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        iter_next  = iter_reg;
        done       = 1'b0;
        bcd_out    = bcd_shift;
        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef SSD_HEX_EN
                    done    = 1'b1;
                    bcd_out = {{(BCD_W - SSD_W){1'b0}}, bin_in};
`else
                    bin_next   = bin_in;
                    bcd_next   = '0;
                    iter_next  = '0;
                    state_next = CONV;
`endif
                end
            end
            CONV: begin
                bin_next  = bin_shift;
                bcd_next  = bcd_shift;
                iter_next = iter_reg + ITER_W'(1);
                if (iter_reg == LAST_ITER) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment driver for the datapath ssd bus.
// Re-converts ssd_in whenever it differs from the last captured value,
// then scans the digit register onto anode/segments with leading-zero
// blanking. Display stays dark until the first conversion completes.
// SSD_HEX_EN: when defined, shows ssd_in as four hex nibbles, no BCD step.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int CLK_DIV_BITS = 18
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [SSD_W-1:0] ssd_in,
    output logic [3:0]       anode,
    output logic [6:0]       segments,
    output logic             busy
);

    logic [CLK_DIV_BITS-1:0] refresh_cnt_reg;
    logic [SSD_W-1:0]        last_val_reg;
    logic                    disp_valid_reg;
    logic [BCD_W-1:0]        digit_reg;
    logic [3:0]              anode_reg;
    logic [6:0]              segments_reg;

    logic                    conv_start;
    logic                    conv_busy;
    logic                    conv_done;
    logic [BCD_W-1:0]        conv_bcd;

    logic [1:0]              sel;
    logic [3:0]              sel_nib;
    logic [BCD_DIGITS-1:0]   blank_vec;
    logic [3:0]              anode_next;
    logic [6:0]              segments_next;

    // A new sample is taken whenever the engine is idle and the bus value
    // has moved, or nothing valid has been shown yet.
    assign conv_start = !conv_busy && ((ssd_in != last_val_reg) || !disp_valid_reg);

    ssd_bcd_conv u_conv (
        .clk     (clk),
        .rst     (Reset),
        .start   (conv_start),
        .bin_in  (ssd_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign busy = conv_busy;

    // Sample tracking and digit register load on conversion completion.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            last_val_reg   <= '0;
            disp_valid_reg <= 1'b0;
            digit_reg      <= '0;
        end else begin
            if (conv_start) begin
                last_val_reg <= ssd_in;
            end
            if (conv_done) begin
                digit_reg      <= conv_bcd;
                disp_valid_reg <= 1'b1;
            end
        end
    end

    // Free-running refresh counter; its top two bits pick the digit.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            refresh_cnt_reg <= '0;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + CLK_DIV_BITS'(1);
        end
    end

    assign sel     = refresh_cnt_reg[CLK_DIV_BITS-1 -: 2];
    assign sel_nib = digit_reg[{sel, 2'b00} +: 4];

    // A digit is blank when it and every higher digit are zero; units never.
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < BCD_DIGITS; gi++) begin : g_blank
            assign blank_vec[gi] = (digit_reg[BCD_W-1:gi*4] == '0);
        end
    endgenerate

    // One-cold anode decode, all off until the display holds valid data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign anode_next[gi] = !(disp_valid_reg && (sel == 2'(gi)));
        end
    endgenerate

    // Segment pattern for the selected digit.
    always_comb begin
        segments_next = SEG_BLANK;
        if (disp_valid_reg && !blank_vec[sel]) begin
            segments_next = seg_encode(sel_nib);
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            anode_reg    <= 4'b1111;
            segments_reg <= SEG_BLANK;
        end else begin
            anode_reg    <= anode_next;
            segments_reg <= segments_next;
        end
    end

    assign anode    = anode_reg;
    assign segments = segments_reg;

endmodule
